// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the fetch PC, keeps one read outstanding to instruction memory and fills IF/ID.
// A delivery lands in IF/ID on the response edge; a stall parks the word in a skid register and no new request goes out until it drains.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] npc_in,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] skid;
  logic [31:0] pc_inc;
  logic        deliver_wait;
  logic        deliver_hold;
  logic        deliver;
  logic [31:0] deliver_inst;

  assign pc_inc       = pc + 32'd4;
  assign deliver_wait = (state == S_WAIT) && imem_rvalid && !stall && !redirect;
  assign deliver_hold = (state == S_HOLD) && !stall && !redirect;
  assign deliver      = deliver_wait || deliver_hold;
  assign deliver_inst = (state == S_HOLD) ? skid : imem_rdata;

  // Gated by rstn so the request drops the instant reset asserts.
  assign imem_req  = rstn && (state == S_REQ) && !redirect;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      skid  <= 32'd0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect) pc <= npc_in;
          else          state <= S_WAIT;
        end
        S_WAIT: begin
          if (redirect) begin
            pc    <= npc_in;
            state <= imem_rvalid ? S_REQ : S_KILL;
          end else if (imem_rvalid) begin
            if (stall) begin
              skid  <= imem_rdata;
              state <= S_HOLD;
            end else begin
              pc    <= pc_inc;
              state <= S_REQ;
            end
          end
        end
        S_KILL: begin
          // The squashed response must drain before the new target is requested.
          if (redirect)    pc <= npc_in;
          if (imem_rvalid) state <= S_REQ;
        end
        S_HOLD: begin
          if (redirect) begin
            pc    <= npc_in;
            state <= S_REQ;
          end else if (!stall) begin
            pc    <= pc_inc;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'd0;
      if_id_inst  <= NOP_INST;
    end else if (redirect) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
    end else if (stall) begin
      if_id_valid <= if_id_valid;
    end else if (deliver) begin
      if_id_valid <= 1'b1;
      if_id_pc    <= pc;
      if_id_inst  <= deliver_inst;
    end else begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: memory responder with variable latency plus a flag-level fetch model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk, rstn, redirect, stall, imem_req, imem_rvalid, if_id_valid;
  logic [31:0] npc_in, imem_addr, imem_rdata, pc, if_id_pc, if_id_inst;

  if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rstn(rstn), .npc_in(npc_in), .redirect(redirect), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .pc(pc), .if_id_pc(if_id_pc),
    .if_id_inst(if_id_inst), .if_id_valid(if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  logic [31:0] m_pc, m_word, e_pc, e_inst;
  logic        m_pending, m_squashed, m_held, e_vld, exp_req;
  // Memory responder
  int          mem_cnt, lat;
  bit          rand_lat;
  logic [31:0] mem_addr;
  // Inputs/observations of the last compare point
  logic        p_r, p_s, p_v, p_req, have_prev;
  logic [31:0] p_n, p_d, p_addr;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h1111_1111;
    if (a == 32'h4) return 32'h2222_2222;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_pending = 0; m_squashed = 0; m_held = 0; m_word = 0;
    e_vld = 0; e_pc = 0; e_inst = NOP;
    mem_cnt = 0; imem_rvalid = 0; have_prev = 0;
  endtask

  task automatic bubble_unless(input logic s);
    if (!s) begin e_vld = 0; e_inst = NOP; end
  endtask

  // Apply the effect of the clock edge that just consumed the last driven inputs.
  task automatic advance();
    if (p_req) begin
      mem_addr = p_addr;
      mem_cnt  = rand_lat ? int'($urandom_range(1, 3)) : lat;
    end
    if (p_r) begin
      if (m_pending && !p_v) m_squashed = 1;
      else begin m_pending = 0; m_squashed = 0; end
      m_held = 0; m_pc = p_n; e_vld = 0; e_inst = NOP;
    end else if (m_pending && p_v) begin
      m_pending = 0;
      if (m_squashed) begin
        m_squashed = 0;
        bubble_unless(p_s);
      end else if (p_s) begin
        m_held = 1; m_word = p_d;
      end else begin
        e_vld = 1; e_pc = m_pc; e_inst = p_d; m_pc = m_pc + 32'd4;
      end
    end else if (m_held && !p_s) begin
      e_vld = 1; e_pc = m_pc; e_inst = m_word; m_pc = m_pc + 32'd4; m_held = 0;
    end else begin
      if (!m_pending && !m_held) m_pending = 1;
      bubble_unless(p_s);
    end
  endtask

  // One cycle: settle the previous edge, drive new inputs at negedge, compare.
  task automatic cyc(input logic r, input logic [31:0] n, input logic s);
    if (have_prev) begin
      @(posedge clk);
      advance();
    end
    @(negedge clk);
    redirect = r; npc_in = n; stall = s;
    imem_rvalid = 0; imem_rdata = $urandom;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin imem_rvalid = 1; imem_rdata = memword(mem_addr); end
    end
    #1;
    exp_req = !m_pending && !m_held && !r;
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    check("pc", pc, m_pc);
    check("if_id_valid", if_id_valid, e_vld);
    check("if_id_pc", if_id_pc, e_pc);
    check("if_id_inst", if_id_inst, e_inst);
    p_r = r; p_n = n; p_s = s; p_v = imem_rvalid; p_d = imem_rdata;
    p_req = imem_req; p_addr = imem_addr; have_prev = 1;
  endtask

  task automatic do_reset();
    rstn = 0; redirect = 0; stall = 0; imem_rvalid = 0;
    #1;
    check("rst imem_req", imem_req, 1'b0);
    check("rst pc", pc, RESET_PC);
    check("rst if_id_valid", if_id_valid, 1'b0);
    check("rst if_id_pc", if_id_pc, 32'd0);
    check("rst if_id_inst", if_id_inst, NOP);
    repeat (2) @(posedge clk);
    model_reset();
    #2 rstn = 1;
  endtask

  task automatic run_until_req(input int max);
    int k = 0;
    cyc(0, 0, 0);
    while (!exp_req && k < max) begin cyc(0, 0, 0); k++; end
    if (!exp_req) begin
      n_cmp++; n_bad++;
      $display("FAIL req_timeout: no request within %0d cycles", max);
    end
  endtask

  task automatic run_until_valid(input int max);
    int k = 0;
    cyc(0, 0, 0);
    while (!e_vld && k < max) begin cyc(0, 0, 0); k++; end
    if (!e_vld) begin
      n_cmp++; n_bad++;
      $display("FAIL valid_timeout: no delivery within %0d cycles", max);
    end
  endtask

  initial begin
    rstn = 1; redirect = 0; stall = 0; npc_in = 0; imem_rvalid = 0; imem_rdata = 0;
    rand_lat = 0; lat = 1;
    model_reset();
    #3;
    do_reset();

    // Streaming with 1-cycle memory
    cyc(0, 0, 0);
    check("s1 req", imem_req, 1'b1);  check("s1 addr", imem_addr, 32'h0);
    cyc(0, 0, 0);
    check("s2 req", imem_req, 1'b0);
    cyc(0, 0, 0);
    check("s3 addr", imem_addr, 32'h4);
    check("s3 ifid", {if_id_valid, if_id_pc, if_id_inst}, {1'b1, 32'h0, 32'h1111_1111});
    cyc(0, 0, 0);
    check("s4 bubble", if_id_valid, 1'b0);
    cyc(0, 0, 0);
    check("s5 addr", imem_addr, 32'h8);
    check("s5 ifid", {if_id_valid, if_id_pc, if_id_inst}, {1'b1, 32'h4, 32'h2222_2222});

    // Stall during response for 8
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("hold pc", pc, 32'h8);  check("hold req", imem_req, 1'b0);
    check("hold ifid_pc", if_id_pc, 32'h4);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("drain req", imem_req, 1'b0);
    cyc(0, 0, 0);
    check("drain ifid", {if_id_valid, if_id_pc, if_id_inst}, {1'b1, 32'h8, memword(32'h8)});
    check("drain pc", pc, 32'hC);

    // Redirect during a 3-cycle read
    lat = 3;
    cyc(1, 32'h100, 0);
    cyc(0, 0, 0);
    check("kill valid", if_id_valid, 1'b0);  check("kill pc", pc, 32'h100);
    run_until_req(10);
    check("redir addr", imem_addr, 32'h100);
    run_until_valid(10);
    check("redir ifid", {if_id_pc, if_id_inst}, {32'h100, memword(32'h100)});

    // Redirect coincident with rvalid and stall
    lat = 1;
    run_until_req(10);
    cyc(1, 32'h400, 1);
    cyc(0, 0, 0);
    check("coinc valid", if_id_valid, 1'b0);
    check("coinc addr", {imem_req, imem_addr}, {1'b1, 32'h400});

    // Two redirects while the stale read is outstanding
    lat = 4;
    cyc(1, 32'h200, 0);
    cyc(1, 32'h300, 0);
    cyc(0, 0, 0);
    check("kill2 req", imem_req, 1'b0);  check("kill2 pc", pc, 32'h300);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("kill2 addr", {imem_req, imem_addr}, {1'b1, 32'h300});

    // PC wrap
    lat = 1;
    cyc(1, 32'hFFFF_FFFC, 0);
    cyc(0, 0, 0);
    check("wrap addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("wrap pc", pc, 32'h0);
    check("wrap ifid", {if_id_valid, if_id_pc}, {1'b1, 32'hFFFF_FFFC});

    // Asynchronous reset with a read outstanding
    lat = 3;
    cyc(0, 0, 0);
    do_reset();

    // Randomized traffic
    rand_lat = 1;
    for (int i = 0; i < 4000; i++) begin
      logic        r, s;
      logic [31:0] n;
      r = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 3) == 0);
      n = $urandom;
      if ($urandom_range(0, 3) != 0) n[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) n = 32'hFFFF_FFFC;
      cyc(r, n, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined CPU; consumer of the next-PC block's outputs (next PC, flush).
- Owns the fetch PC register, issues one-outstanding-request reads to instruction memory, and fills the IF/ID pipeline register.
- Honours hazard-unit stall and squashes wrong-path fetches on redirect.
- Drives the fetch PC back to the next-PC block as its PC input.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction word presented on if_id_inst when the slot is invalid (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- npc_in  in  32  redirect target from the next-PC block.
- redirect  in  1  flush from the next-PC block; when 1, npc_in is the new fetch PC and all younger fetch work is discarded.
- stall  in  1  hazard-unit stall; IF/ID holds its contents.
- imem_req  out  1  single-cycle read request; always accepted by memory.
- imem_addr  out  32  request address (word aligned).
- imem_rvalid  in  1  read data valid; arrives 1 or more cycles after imem_req, in order.
- imem_rdata  in  32  instruction word.
- pc  out  32  current fetch PC (to the next-PC block).
- if_id_pc  out  32  PC of the instruction in IF/ID.
- if_id_inst  out  32  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a live instruction.

Behaviour:
- Reset (asynchronous, any time, including mid-request):
  - pc=RESET_PC, state=S_REQ, skid buffer empty.
  - if_id_valid=0, if_id_pc=0, if_id_inst=NOP_INST, imem_req=0.
  - Any in-flight memory response after reset release is not the bench's concern; memory is reset together with this block.
- At most one outstanding request.
- imem_addr=pc whenever imem_req=1.
- State S_REQ:
  - imem_req = !redirect.
  - redirect: pc<=npc_in, stay in S_REQ.
  - Otherwise go to S_WAIT.
- State S_WAIT (request outstanding):
  - rvalid && redirect: discard data, pc<=npc_in, go to S_REQ.
  - redirect && !rvalid: pc<=npc_in, go to S_KILL.
  - rvalid && !stall: IF/ID <= {pc, rdata, valid=1}, pc<=pc+4, go to S_REQ.
  - rvalid && stall: skid <= rdata, go to S_HOLD; pc is unchanged.
  - Otherwise stay in S_WAIT.
- State S_KILL (squashed request outstanding):
  - rvalid: discard data, go to S_REQ.
  - redirect: pc<=npc_in, stay in S_KILL until rvalid.
- State S_HOLD:
  - redirect: drop skid, pc<=npc_in, go to S_REQ.
  - !stall: IF/ID <= {pc, skid, 1}, pc<=pc+4, go to S_REQ.
  - Otherwise stay in S_HOLD.
- IF/ID update priority, highest first:
  - redirect: valid<=0, inst<=NOP_INST; overrides stall.
  - stall: hold all fields.
  - Delivery: load as above.
  - Otherwise: valid<=0, inst<=NOP_INST (bubble); if_id_pc holds its value.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- npc_in is not realigned; bits [1:0] pass through unchanged.
- Throughput: with 1-cycle memory latency and no stall, one instruction every 2 cycles (request cycle, then response cycle).
- Latency: from the redirect cycle to the first request at the new target is 1 cycle (S_REQ in the next cycle). If a stale response is still pending, the new request waits for that response first.

Test Plan:
- Reset release, memory returns 0x11111111 @0 and 0x22222222 @4 with 1-cycle latency, no stall -> imem_addr 0,4,8 on alternate cycles; IF/ID shows {0,0x11111111,1}, then bubble, then {4,0x22222222,1}.
- Response for addr 8 arrives while stall=1 for 3 cycles -> IF/ID holds {4,…}; pc stays 8; the cycle after stall drops, IF/ID={8,rdata,1}; no extra request is issued while in S_HOLD.
- redirect=1, npc_in=0x100 in S_WAIT with 3-cycle memory latency -> IF/ID valid=0 the next cycle; stale data is discarded on rvalid; the next imem_req has addr 0x100; the instruction from 0x100 appears in IF/ID.
- redirect coincident with rvalid, and redirect coincident with stall=1 -> data dropped, if_id_valid=0 despite stall, pc=npc_in.
- Two redirects during S_KILL (0x200 then 0x300) -> only 0x300 is fetched after the stale response.
- pc=0xFFFF_FFFC delivered -> pc wraps to 0; rstn pulsed low mid-S_WAIT -> outputs at reset values immediately, with no clock edge required.
